// File: rtl/bist_engine.sv
// rtl/bist_engine.sv - LFSR pattern generator with MISR response compactor and pass/fail compare
//
// Purpose:
//   Runs one built-in self test per START request. An 8-bit Fibonacci LFSR
//   drives PATTERN into the unit under test. The combinational response
//   DUT_RESP is folded into a 16-bit MISR on every RUN cycle. At the end of
//   the run the MISR is compared with GOLDEN.
//
// Ports:
//   CLK            in   1   system clock, rising edge
//   RST            in   1   asynchronous active-high reset
//   START          in   1   level request; looked at only in IDLE and DONE
//   BIST_CONF_REG  in  13   [0] mode (0 preset, 1 user), [4:1] preset test
//                           number, [12:5] user length (0 means 256)
//   DUT_RESP       in   8   response of the unit under test to PATTERN
//   GOLDEN         in  16   expected signature
//   PATTERN        out  8   current LFSR state
//   PATTERN_VALID  out  1   high while PATTERN is being applied (RUN)
//   BUSY           out  1   high in LOAD and RUN
//   DONE           out  1   high in DONE
//   SIGNATURE      out 16   MISR contents
//   PASS           out  1   SIGNATURE == GOLDEN, forced low outside DONE

module bist_engine (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [12:0] BIST_CONF_REG,
    input  logic [7:0]  DUT_RESP,
    input  logic [15:0] GOLDEN,
    output logic [7:0]  PATTERN,
    output logic        PATTERN_VALID,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] SIGNATURE,
    output logic        PASS
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // MISR feedback polynomial x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;
    // LFSR taps at bits 7, 5, 4, 3
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [8:0]  FULL_LEN  = 9'd256;

    state_t      state_q;
    state_t      state_next;

    logic [12:0] conf_q;
    logic [7:0]  lfsr_q;
    logic [15:0] misr_q;
    logic [8:0]  count_q;

    logic [7:0]  seed;
    logic [8:0]  length;
    logic [7:0]  lfsr_next;
    logic [15:0] misr_next;

    // ------------------------------------------------------------------
    // Configuration decode. The snapshot is captured as the block enters
    // LOAD, so the whole LOAD cycle works from a copy that the host can no
    // longer disturb; nothing after that point looks at BIST_CONF_REG.
    // ------------------------------------------------------------------
    always_comb begin
        seed   = 8'hFF;
        length = FULL_LEN;
        if (conf_q[0]) begin
            seed = 8'hFF;
            if (conf_q[12:5] == 8'd0) begin
                length = FULL_LEN;
            end else begin
                length = {1'b0, conf_q[12:5]};
            end
        end else begin
            seed   = {4'hA, conf_q[4:1]};
            length = FULL_LEN;
        end
    end

    // ------------------------------------------------------------------
    // Pattern and signature next-state functions
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_next = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_comb begin
        misr_next = {misr_q[14:0], 1'b0}
                  ^ (misr_q[15] ? MISR_POLY : 16'h0000)
                  ^ {8'h00, DUT_RESP};
    end

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                // count_q holds the cycles still to run including this one,
                // so leaving on 1 gives exactly 'length' RUN cycles.
                if (count_q == 9'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // No auto-restart: START must drop before a new run.
                if (!START) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            conf_q  <= 13'd0;
            lfsr_q  <= 8'h00;
            misr_q  <= 16'h0000;
            count_q <= 9'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        conf_q <= BIST_CONF_REG;
                    end
                end
                ST_LOAD: begin
                    misr_q  <= 16'h0000;
                    lfsr_q  <= seed;
                    count_q <= length;
                end
                ST_RUN: begin
                    // DUT_RESP is the response to the PATTERN currently
                    // driven, captured on the same edge that advances it.
                    misr_q  <= misr_next;
                    lfsr_q  <= lfsr_next;
                    count_q <= count_q - 9'd1;
                end
                default: begin
                    // DONE holds the signature and pattern stable.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        PATTERN       = lfsr_q;
        SIGNATURE     = misr_q;
        PATTERN_VALID = (state_q == ST_RUN);
        BUSY          = (state_q == ST_LOAD) || (state_q == ST_RUN);
        DONE          = (state_q == ST_DONE);
        PASS          = (state_q == ST_DONE) && (misr_q == GOLDEN);
    end

endmodule

// File: tb/tb_bist_engine.sv
// tb/tb_bist_engine.sv - self-checking bench for bist_engine

module tb_bist_engine;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [12:0] BIST_CONF_REG;
    logic [7:0]  DUT_RESP;
    logic [15:0] GOLDEN;
    logic [7:0]  PATTERN;
    logic        PATTERN_VALID;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SIGNATURE;
    logic        PASS;

    int errors = 0;
    int checks = 0;

    // Unit-under-test stand-in: response is a table lookup on the pattern.
    logic [7:0] resp_tbl [256];
    assign DUT_RESP = resp_tbl[PATTERN];

    logic [7:0] got_pat [$];
    bit         done_seen;
    logic [15:0] last_sig;

    bist_engine dut (
        .CLK           (CLK),
        .RST           (RST),
        .START         (START),
        .BIST_CONF_REG (BIST_CONF_REG),
        .DUT_RESP      (DUT_RESP),
        .GOLDEN        (GOLDEN),
        .PATTERN       (PATTERN),
        .PATTERN_VALID (PATTERN_VALID),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .SIGNATURE     (SIGNATURE),
        .PASS          (PASS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic void exp_cfg(input logic [12:0] c, output logic [7:0] seed, output int len);
        if (c[0]) begin
            seed = 8'hFF;
            len  = (c[12:5] == 8'd0) ? 256 : int'(c[12:5]);
        end else begin
            seed = {4'hA, c[4:1]};
            len  = 256;
        end
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] p);
        return {p[6:0], ^(p & 8'hB8)};
    endfunction

    // Multiply by x modulo the CCITT polynomial, then add the response.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ 17'h11021;
        return t[15:0] ^ {8'h00, r};
    endfunction

    function automatic logic [15:0] model_sig(input logic [12:0] c);
        logic [7:0]  p;
        logic [15:0] s;
        int          n;
        exp_cfg(c, p, n);
        s = 16'h0000;
        for (int i = 0; i < n; i++) begin
            s = misr_step(s, resp_tbl[p]);
            p = lfsr_step(p);
        end
        return s;
    endfunction

    task automatic fill_tbl(input int kind);
        for (int i = 0; i < 256; i++) begin
            if (kind == 0)      resp_tbl[i] = 8'h00;
            else if (kind == 1) resp_tbl[i] = 8'h01;
            else                resp_tbl[i] = 8'($urandom);
        end
    endtask

    // One complete run with checks against the model.
    task automatic do_run(input logic [12:0] conf, input bit hold, input bit perturb);
        logic [7:0]  p;
        int          n;
        int          bad;
        logic [15:0] es;
        BIST_CONF_REG = conf;
        got_pat.delete();
        START = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1 || PATTERN_VALID !== 1'b0 || DONE !== 1'b0)
            begin errors++; $display("FAIL load_state: busy=%b valid=%b done=%b, want 1 0 0", BUSY, PATTERN_VALID, DONE); end
        if (!hold) START = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 300 && !done_seen; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                done_seen = 1'b1;
            end else if (PATTERN_VALID === 1'b1) begin
                if (got_pat.size() == 0) begin
                    checks++;
                    if (SIGNATURE !== 16'h0000)
                        begin errors++; $display("FAIL sig_restart: got %h want 0000", SIGNATURE); end
                end
                got_pat.push_back(PATTERN);
                if (perturb && got_pat.size() == 3) BIST_CONF_REG = ~conf;
            end
        end
        checks++;
        if (!done_seen) begin errors++; $display("FAIL done_timeout: DONE not seen within 300 cycles"); end

        exp_cfg(conf, p, n);
        es = model_sig(conf);
        checks++;
        if (got_pat.size() != n)
            begin errors++; $display("FAIL run_length: got %0d want %0d", got_pat.size(), n); end
        bad = 0;
        for (int i = 0; i < got_pat.size() && i < n; i++) begin
            if (got_pat[i] !== p) bad++;
            p = lfsr_step(p);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pattern_seq: %0d wrong patterns, want 0", bad); end
        checks++;
        if (SIGNATURE !== es) begin errors++; $display("FAIL signature: got %h want %h", SIGNATURE, es); end
        GOLDEN = es;
        #1;
        checks++;
        if (PASS !== 1'b1) begin errors++; $display("FAIL pass_match: got %b want 1", PASS); end
        GOLDEN = es ^ 16'h0001;
        #1;
        checks++;
        if (PASS !== 1'b0) begin errors++; $display("FAIL pass_mismatch: got %b want 0", PASS); end
        last_sig = es;
        if (!hold) begin
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || PASS !== 1'b0)
                begin errors++; $display("FAIL back_to_idle: done=%b busy=%b pass=%b want 0 0 0", DONE, BUSY, PASS); end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (PATTERN !== 8'h00 || PATTERN_VALID !== 1'b0 || BUSY !== 1'b0 ||
            DONE !== 1'b0 || SIGNATURE !== 16'h0000 || PASS !== 1'b0)
            begin
                errors++;
                $display("FAIL %s: pat=%h valid=%b busy=%b done=%b sig=%h pass=%b want 00 0 0 0 0000 0",
                         tag, PATTERN, PATTERN_VALID, BUSY, DONE, SIGNATURE, PASS);
            end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        START = 1'b0;
        BIST_CONF_REG = 13'd0;
        GOLDEN = 16'h0000;
        fill_tbl(0);
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset_values");
        RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_user_len6();
        logic [7:0] exp6 [6];
        int         bad;
        exp6 = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
        fill_tbl(0);
        do_run({8'd6, 4'd0, 1'b1}, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 6 && i < got_pat.size(); i++)
            if (got_pat[i] !== exp6[i]) bad++;
        checks++;
        if (bad != 0 || got_pat.size() != 6)
            begin errors++; $display("FAIL len6_fixed_seq: %0d wrong of %0d, want 0 of 6", bad, got_pat.size()); end
        checks++;
        if (SIGNATURE !== 16'h0000 || DONE !== 1'b1)
            begin errors++; $display("FAIL len6_sig: sig=%h done=%b want 0000 1", SIGNATURE, DONE); end
        START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_len2_pass();
        fill_tbl(1);
        do_run({8'd2, 4'd0, 1'b1}, 1'b1, 1'b0);
        checks++;
        if (SIGNATURE !== 16'h0003) begin errors++; $display("FAIL len2_sig: got %h want 0003", SIGNATURE); end
        GOLDEN = 16'h0003;
        #1;
        checks++;
        if (PASS !== 1'b1) begin errors++; $display("FAIL len2_pass_hi: got %b want 1", PASS); end
        GOLDEN = 16'h0001;
        #1;
        checks++;
        if (PASS !== 1'b0) begin errors++; $display("FAIL len2_pass_lo: got %b want 0", PASS); end
        START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_full_length();
        fill_tbl(2);
        do_run({8'd0, 4'($urandom), 1'b1}, 1'b0, 1'b0);
        do_run({8'($urandom), 4'd5, 1'b0}, 1'b0, 1'b0);
        checks++;
        if (got_pat.size() == 0 || got_pat[0] !== 8'hA5)
            begin errors++; $display("FAIL preset5_first: got %h want a5", got_pat.size() ? got_pat[0] : 8'hxx); end
    endtask

    task automatic test_conf_change();
        fill_tbl(2);
        do_run({8'($urandom_range(8, 40)), 4'($urandom), 1'b1}, 1'b0, 1'b1);
        do_run({8'($urandom), 4'($urandom), 1'b0}, 1'b0, 1'b1);
    endtask

    task automatic test_hold_start();
        int bad;
        fill_tbl(2);
        do_run({8'($urandom_range(10, 60)), 4'd0, 1'b1}, 1'b1, 1'b0);
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (DONE !== 1'b1 || BUSY !== 1'b0 || SIGNATURE !== last_sig) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_done: %0d unstable cycles, want 0", bad); end
        START = 1'b0;
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0)
            begin errors++; $display("FAIL release_idle: done=%b busy=%b want 0 0", DONE, BUSY); end
        do_run({8'($urandom_range(3, 30)), 4'd0, 1'b1}, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        fill_tbl(2);
        BIST_CONF_REG = {8'd10, 4'd0, 1'b1};
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (PATTERN_VALID !== 1'b1) begin errors++; $display("FAIL midrun_running: valid=%b want 1", PATTERN_VALID); end
        #2 RST = 1'b1;
        #1;
        check_reset_outputs("async_abort");
        @(negedge CLK);
        RST = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || BUSY !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_no_done: block left IDLE after abort, want stay idle"); end
    endtask

    task automatic test_random_runs();
        logic [12:0] c;
        for (int k = 0; k < 4; k++) begin
            fill_tbl(2);
            c = 13'($urandom);
            if (c[0]) c[12:5] = 8'($urandom_range(0, 50));
            do_run(c, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_user_len6();
        test_len2_pass();
        test_full_length();
        test_conf_change();
        test_hold_start();
        test_reset_midrun();
        test_random_runs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bist_engine.md
BIST_ENGINE -- requirements
Module: bist_engine

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port START  input  1  level request to run one test; sampled only in IDLE and DONE.
REQ-004 SHALL have port BIST_CONF_REG  input  13  test configuration: [0] mode (0 preset, 1 user), [4:1] preset test number, [12:5] user test length.
REQ-005 SHALL have port DUT_RESP  input  8  response of the unit under test to the current PATTERN.
REQ-006 SHALL have port GOLDEN  input  16  expected signature for the pass/fail compare.
REQ-007 SHALL have port PATTERN  output  8  current test vector (LFSR state).
REQ-008 SHALL have port PATTERN_VALID  output  1  high only while PATTERN is being applied (RUN).
REQ-009 SHALL have port BUSY  output  1  high in LOAD and RUN.
REQ-010 SHALL have port DONE  output  1  high in DONE state.
REQ-011 SHALL have port SIGNATURE  output  16  MISR contents.
REQ-012 SHALL have port PASS  output  1  SIGNATURE == GOLDEN, qualified by DONE (0 outside DONE).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-014 IDLE -> LOAD on an edge with START=1; otherwise stay in IDLE.
REQ-015 LOAD (exactly 1 cycle) SHALL snapshot BIST_CONF_REG; later changes to BIST_CONF_REG SHALL have no effect until the next LOAD.
REQ-016 In LOAD: MISR <= 16'h0000; LFSR <= seed; 9-bit counter <= length; state -> RUN.
REQ-017 Preset mode: seed = {4'hA, test number}; length = 256.
REQ-018 User mode: seed = 8'hFF; length = field value, with field 0 meaning 256.
REQ-019 LFSR: 8-bit Fibonacci, shift left, bit0 <= q[7]^q[5]^q[4]^q[3]; all-zero state unreachable.
REQ-020 Each RUN edge: MISR <= ({MISR[14:0],1'b0} ^ (MISR[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, DUT_RESP}; LFSR advances; counter decrements.
REQ-021 DUT_RESP SHALL be sampled at the same edge that advances PATTERN (combinational DUT path, zero added latency).
REQ-022 RUN -> DONE at the edge where counter == 1, so RUN lasts exactly length cycles and exactly length responses are compressed.
REQ-023 DONE SHALL hold SIGNATURE stable and stay in DONE while START=1; DONE -> IDLE on an edge with START=0 (no auto-restart).
REQ-024 PATTERN SHALL equal LFSR state at all times; in RUN, first PATTERN = seed.
REQ-025 Timing: START sampled at edge 0 -> LOAD; edge 1 -> RUN; DONE high from edge 1+length.

Reset
REQ-026 RST=1 SHALL asynchronously force state IDLE, LFSR 8'h00, counter 0, MISR 16'h0000, snapshot 0.
REQ-027 Output reset values: PATTERN 8'h00, PATTERN_VALID 0, BUSY 0, DONE 0, SIGNATURE 16'h0000, PASS 0.
REQ-028 RST asserted mid-RUN SHALL abort the test immediately with no partial DONE; after release the block waits in IDLE for START.

Verification
REQ-029 User mode, length 6, DUT_RESP=8'h00, START pulse -> PATTERN sequence FF, FE, FC, F8, F0, E1 with PATTERN_VALID high exactly 6 cycles; SIGNATURE 16'h0000; DONE high.
REQ-030 User mode, length 2, DUT_RESP=8'h01 constant -> SIGNATURE 16'h0003; with GOLDEN=16'h0003 PASS=1, with GOLDEN=16'h0001 PASS=0.
REQ-031 User mode, length field 0 -> PATTERN_VALID high exactly 256 cycles; preset mode, test number 5 -> first PATTERN 8'hA5, 256 RUN cycles.
REQ-032 BIST_CONF_REG changed to a different mode/length during RUN -> run length and pattern sequence unchanged from the LOAD snapshot.
REQ-033 START held high through DONE -> DONE stays high, no restart; START low -> IDLE next edge; START high again -> new run, SIGNATURE restarts from 16'h0000.
REQ-034 RST pulsed on cycle 3 of RUN -> all outputs at reset values immediately, without waiting for a CLK edge; DONE never asserted for the aborted run.
